// File: rtl/opendap_sw_dp_ap_sequencer.sv
// opendap_sw_dp_ap_sequencer: turns SW-DP AP accesses into held AP requests with posted-read RDBUFF and sticky error.
//   swclk, rst_n            : clock and asynchronous active-low reset
//   bus_*                   : single-cycle access from the serial front end (bus_en strobe)
//   select_apsel/apbanksel  : current DP SELECT fields, latched at accept
//   abort, clr_sticky_err   : ABORT.DAPABORT / ABORT.STKERRCLR pulses
//   ap_rdy                  : no AP transaction outstanding
//   rdbuff                  : result of the last successful AP read
//   sticky_err              : CTRL/STAT.STICKYERR
//   ap_req/sel/addr/write/wdata : downstream request, held stable until ap_ack or abort
//   ap_ack/rdata/slverr     : downstream completion
module opendap_sw_dp_ap_sequencer #(
    parameter int W_APSEL  = 8,
    parameter int W_APBANK = 4
) (
    input  logic                  swclk,
    input  logic                  rst_n,
    input  logic [1:0]            bus_addr,
    input  logic                  bus_r_nw,
    input  logic                  bus_ap_ndp,
    input  logic [31:0]           bus_wdata,
    input  logic                  bus_en,
    input  logic [W_APSEL-1:0]    select_apsel,
    input  logic [W_APBANK-1:0]   select_apbanksel,
    input  logic                  abort,
    input  logic                  clr_sticky_err,
    output logic                  ap_rdy,
    output logic [31:0]           rdbuff,
    output logic                  sticky_err,
    output logic                  ap_req,
    output logic [W_APSEL-1:0]    ap_sel,
    output logic [W_APBANK+1:0]   ap_addr,
    output logic                  ap_write,
    output logic [31:0]           ap_wdata,
    input  logic                  ap_ack,
    input  logic [31:0]           ap_rdata,
    input  logic                  ap_slverr
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;
    logic start, done;
    // Accepts only from IDLE; a strobe while BUSY is a front-end violation and is dropped.
    assign start = bus_en && bus_ap_ndp && (state == IDLE);
    // Abort wins over a coincident ack, so the ack's data and error are discarded.
    assign done  = (state == BUSY) && ap_ack && !abort;
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE && start)                 state_nxt = BUSY;
        else if (state == BUSY && (abort || ap_ack)) state_nxt = IDLE;
    end
    always_comb begin
        ap_req = (state == BUSY);
        ap_rdy = (state == IDLE);
    end
    always_ff @(posedge swclk or negedge rst_n) begin
        if (!rst_n) begin
            ap_sel     <= '0;
            ap_addr    <= '0;
            ap_write   <= 1'b0;
            ap_wdata   <= '0;
            rdbuff     <= '0;
            sticky_err <= 1'b0;
        end else begin
            if (start) begin
                ap_sel   <= select_apsel;
                ap_addr  <= {select_apbanksel, bus_addr};
                ap_write <= ~bus_r_nw;
                ap_wdata <= bus_wdata;
            end
            if (done && !ap_write && !ap_slverr) rdbuff <= ap_rdata;
            // Set has priority over a coincident clear.
            if (done && ap_slverr)  sticky_err <= 1'b1;
            else if (clr_sticky_err) sticky_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_opendap_sw_dp_ap_sequencer.sv
// tb_opendap_sw_dp_ap_sequencer: directed self-checking bench for the SW-DP AP sequencer.
module tb_opendap_sw_dp_ap_sequencer;
    logic        swclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  bus_addr = '0;
    logic        bus_r_nw = 1'b0;
    logic        bus_ap_ndp = 1'b0;
    logic [31:0] bus_wdata = '0;
    logic        bus_en = 1'b0;
    logic [7:0]  select_apsel = '0;
    logic [3:0]  select_apbanksel = '0;
    logic        abort = 1'b0;
    logic        clr_sticky_err = 1'b0;
    logic        ap_rdy;
    logic [31:0] rdbuff;
    logic        sticky_err;
    logic        ap_req;
    logic [7:0]  ap_sel;
    logic [5:0]  ap_addr;
    logic        ap_write;
    logic [31:0] ap_wdata;
    logic        ap_ack = 1'b0;
    logic [31:0] ap_rdata = '0;
    logic        ap_slverr = 1'b0;
    int total = 0;
    int bad = 0;

    opendap_sw_dp_ap_sequencer #(.W_APSEL(8), .W_APBANK(4)) dut (
        .swclk(swclk), .rst_n(rst_n), .bus_addr(bus_addr), .bus_r_nw(bus_r_nw),
        .bus_ap_ndp(bus_ap_ndp), .bus_wdata(bus_wdata), .bus_en(bus_en),
        .select_apsel(select_apsel), .select_apbanksel(select_apbanksel),
        .abort(abort), .clr_sticky_err(clr_sticky_err), .ap_rdy(ap_rdy),
        .rdbuff(rdbuff), .sticky_err(sticky_err), .ap_req(ap_req), .ap_sel(ap_sel),
        .ap_addr(ap_addr), .ap_write(ap_write), .ap_wdata(ap_wdata),
        .ap_ack(ap_ack), .ap_rdata(ap_rdata), .ap_slverr(ap_slverr)
    );

    always #5 swclk = ~swclk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge swclk);
        @(negedge swclk);
    endtask

    task automatic issue(input logic rd, input logic ap, input logic [1:0] a, input logic [31:0] wd);
        bus_en = 1'b1; bus_r_nw = rd; bus_ap_ndp = ap; bus_addr = a; bus_wdata = wd;
        cyc();
        bus_en = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd, input logic err);
        ap_ack = 1'b1; ap_rdata = rd; ap_slverr = err;
        cyc();
        ap_ack = 1'b0; ap_slverr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if ({ap_req, ap_rdy, sticky_err, ap_write} !== 4'b0100) begin bad++; $display("FAIL reset_flags got %b want 0100", {ap_req, ap_rdy, sticky_err, ap_write}); end
        total++; if ({rdbuff, ap_wdata, ap_sel, ap_addr} !== 78'h0) begin bad++; $display("FAIL reset_data got %h want 0", {rdbuff, ap_wdata, ap_sel, ap_addr}); end
        @(negedge swclk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_posted_read();
        select_apsel = 8'h5A; select_apbanksel = 4'h2;
        total++; if (rdbuff !== 32'h0) begin bad++; $display("FAIL pr_preload got %h want 0", rdbuff); end
        issue(1'b1, 1'b1, 2'd1, 32'h0);
        total++; if ({ap_req, ap_rdy, ap_write} !== 3'b100) begin bad++; $display("FAIL pr_req got %b want 100", {ap_req, ap_rdy, ap_write}); end
        total++; if (ap_addr !== 6'h09) begin bad++; $display("FAIL pr_addr got %h want 09", ap_addr); end
        total++; if (ap_sel !== 8'h5A) begin bad++; $display("FAIL pr_sel got %h want 5a", ap_sel); end
        ack(32'hCAFEF00D, 1'b0);
        total++; if (rdbuff !== 32'hCAFEF00D) begin bad++; $display("FAIL pr_rdbuff got %h want cafef00d", rdbuff); end
        total++; if ({ap_req, ap_rdy} !== 2'b01) begin bad++; $display("FAIL pr_done got %b want 01", {ap_req, ap_rdy}); end
        bus_en = 1'b1; bus_r_nw = 1'b1; bus_ap_ndp = 1'b1; bus_addr = 2'd1;
        total++; if (rdbuff !== 32'hCAFEF00D) begin bad++; $display("FAIL pr_posted got %h want cafef00d", rdbuff); end
        cyc();
        bus_en = 1'b0;
        ack(32'h11111111, 1'b0);
        total++; if (rdbuff !== 32'h11111111) begin bad++; $display("FAIL pr_second got %h want 11111111", rdbuff); end
    endtask

    task automatic test_write();
        issue(1'b0, 1'b1, 2'd0, 32'h12345678);
        for (int i = 0; i < 6; i++) begin
            total++; if ({ap_req, ap_rdy, ap_write} !== 3'b101 || ap_wdata !== 32'h12345678 || ap_addr !== 6'h08) begin
                bad++; $display("FAIL wr_hold%0d got req/rdy/wr=%b wdata=%h addr=%h want 101 12345678 08", i, {ap_req, ap_rdy, ap_write}, ap_wdata, ap_addr);
            end
            if (i == 5) ack(32'hBADBAD00, 1'b0); else cyc();
        end
        total++; if ({ap_req, ap_rdy} !== 2'b01) begin bad++; $display("FAIL wr_done got %b want 01", {ap_req, ap_rdy}); end
        total++; if (rdbuff !== 32'h11111111) begin bad++; $display("FAIL wr_rdbuff got %h want 11111111", rdbuff); end
    endtask

    task automatic test_slverr();
        issue(1'b1, 1'b1, 2'd2, 32'h0);
        ack(32'hFFFFFFFF, 1'b1);
        total++; if (sticky_err !== 1'b1) begin bad++; $display("FAIL se_set got %b want 1", sticky_err); end
        total++; if (rdbuff !== 32'h11111111) begin bad++; $display("FAIL se_rdbuff got %h want 11111111", rdbuff); end
        issue(1'b1, 1'b1, 2'd2, 32'h0);
        clr_sticky_err = 1'b1;
        ack(32'hFFFFFFFF, 1'b1);
        clr_sticky_err = 1'b0;
        total++; if (sticky_err !== 1'b1) begin bad++; $display("FAIL se_setwins got %b want 1", sticky_err); end
        clr_sticky_err = 1'b1;
        cyc();
        clr_sticky_err = 1'b0;
        total++; if (sticky_err !== 1'b0) begin bad++; $display("FAIL se_clr got %b want 0", sticky_err); end
    endtask

    task automatic test_abort();
        issue(1'b1, 1'b1, 2'd3, 32'h0);
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        total++; if ({ap_req, ap_rdy} !== 2'b01) begin bad++; $display("FAIL ab_idle got %b want 01", {ap_req, ap_rdy}); end
        ack(32'hDEADBEEF, 1'b1);
        total++; if (rdbuff !== 32'h11111111 || sticky_err !== 1'b0 || ap_req !== 1'b0) begin
            bad++; $display("FAIL ab_late_ack got rdbuff=%h sticky=%b req=%b want 11111111 0 0", rdbuff, sticky_err, ap_req);
        end
        issue(1'b1, 1'b1, 2'd3, 32'h0);
        abort = 1'b1;
        ack(32'hDEADBEEF, 1'b1);
        abort = 1'b0;
        total++; if (rdbuff !== 32'h11111111 || sticky_err !== 1'b0 || ap_rdy !== 1'b1) begin
            bad++; $display("FAIL ab_coincident got rdbuff=%h sticky=%b rdy=%b want 11111111 0 1", rdbuff, sticky_err, ap_rdy);
        end
    endtask

    task automatic test_violation_dp();
        issue(1'b0, 1'b1, 2'd1, 32'hAAAA0000);
        issue(1'b0, 1'b1, 2'd2, 32'h55555555);
        total++; if (ap_wdata !== 32'hAAAA0000 || ap_addr !== 6'h09 || ap_req !== 1'b1) begin
            bad++; $display("FAIL pv_latch got wdata=%h addr=%h req=%b want aaaa0000 09 1", ap_wdata, ap_addr, ap_req);
        end
        ack(32'h0, 1'b0);
        cyc();
        total++; if (ap_req !== 1'b0) begin bad++; $display("FAIL pv_single got %b want 0", ap_req); end
        issue(1'b1, 1'b0, 2'd3, 32'h0);
        total++; if ({ap_req, ap_rdy} !== 2'b01 || rdbuff !== 32'h11111111) begin
            bad++; $display("FAIL dp_rdbuff got req/rdy=%b rdbuff=%h want 01 11111111", {ap_req, ap_rdy}, rdbuff);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        total++; if ({ap_req, ap_rdy} !== 2'b01) begin bad++; $display("FAIL idle_abort got %b want 01", {ap_req, ap_rdy}); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 1'b1, 2'd0, 32'h0);
        bus_en = 1'b1; bus_r_nw = 1'b1; bus_ap_ndp = 1'b1; bus_addr = 2'd2;
        ack(32'h22222222, 1'b0);
        bus_en = 1'b0;
        total++; if ({ap_req, ap_rdy} !== 2'b01 || rdbuff !== 32'h22222222) begin
            bad++; $display("FAIL b2b_same_edge got req/rdy=%b rdbuff=%h want 01 22222222", {ap_req, ap_rdy}, rdbuff);
        end
        issue(1'b1, 1'b1, 2'd2, 32'h0);
        total++; if (ap_req !== 1'b1 || ap_addr !== 6'h0A) begin bad++; $display("FAIL b2b_next got req=%b addr=%h want 1 0a", ap_req, ap_addr); end
        ack(32'h33333333, 1'b0);
        total++; if (rdbuff !== 32'h33333333) begin bad++; $display("FAIL b2b_data got %h want 33333333", rdbuff); end
    endtask

    task automatic test_reset_mid();
        ap_rdata = 32'h0;
        issue(1'b0, 1'b1, 2'd3, 32'h77777777);
        ack(32'h0, 1'b1);
        issue(1'b0, 1'b1, 2'd3, 32'h77777777);
        total++; if (ap_req !== 1'b1 || sticky_err !== 1'b1) begin bad++; $display("FAIL rm_busy got req=%b sticky=%b want 1 1", ap_req, sticky_err); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (ap_req !== 1'b0) begin bad++; $display("FAIL rm_async got %b want 0", ap_req); end
        total++; if ({ap_rdy, sticky_err, ap_write} !== 3'b100 || {rdbuff, ap_wdata, ap_sel, ap_addr} !== 78'h0) begin
            bad++; $display("FAIL rm_values got rdy/sticky/wr=%b data=%h want 100 0", {ap_rdy, sticky_err, ap_write}, {rdbuff, ap_wdata, ap_sel, ap_addr});
        end
        @(negedge swclk);
        rst_n = 1'b1;
        cyc();
        total++; if ({ap_req, ap_rdy} !== 2'b01) begin bad++; $display("FAIL rm_after got %b want 01", {ap_req, ap_rdy}); end
    endtask

    initial begin
        test_reset();
        test_posted_read();
        test_write();
        test_slverr();
        test_abort();
        test_violation_dp();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/opendap_sw_dp_ap_sequencer.md
Name: opendap_sw_dp_ap_sequencer

Overview:
Sequences AP accesses issued by the SW-DP serial front end onto the downstream AP request/acknowledge bus. It captures each AP access on bus_en and drives ap_rdy for the front end's WAIT/OK decision. It implements posted-read semantics by holding the read buffer (RDBUFF) and sets the sticky error flag on slave errors. It sits between the serial comms block and the AP interconnect, alongside the DP register file.

Parameters:
W_APSEL, 8, width of the AP select field taken from DP SELECT.APSEL
W_APBANK, 4, width of the AP bank select field taken from DP SELECT.APBANKSEL

Ports:
swclk  input  1  SWD clock; all state changes on posedge
rst_n  input  1  asynchronous active-low reset
bus_addr  input  2  access address A[3:2] from the serial front end
bus_r_nw  input  1  1 = read, 0 = write
bus_ap_ndp  input  1  1 = AP access, 0 = DP access
bus_wdata  input  32  write data
bus_en  input  1  single-cycle access strobe
select_apsel  input  W_APSEL  current SELECT.APSEL
select_apbanksel  input  W_APBANK  current SELECT.APBANKSEL
abort  input  1  ABORT.DAPABORT pulse
clr_sticky_err  input  1  ABORT.STKERRCLR pulse
ap_rdy  output  1  high when no AP transaction is outstanding
rdbuff  output  32  read buffer; DP read mux source for AP reads and RDBUFF reads
sticky_err  output  1  CTRL/STAT.STICKYERR
ap_req  output  1  downstream request, held until acknowledged
ap_sel  output  W_APSEL  latched APSEL
ap_addr  output  W_APBANK+2  latched {APBANKSEL, bus_addr}
ap_write  output  1  latched ~bus_r_nw
ap_wdata  output  32  latched write data
ap_ack  input  1  downstream completion pulse, valid only while ap_req is high
ap_rdata  input  32  read data, valid with ap_ack
ap_slverr  input  1  error response, valid with ap_ack

Behaviour:
- Reset values: ap_req=0, ap_rdy=1, rdbuff=0, sticky_err=0, ap_sel=0, ap_addr=0, ap_write=0, ap_wdata=0. ap_req falls asynchronously on reset, including in the middle of a transaction.
- States: IDLE and BUSY. ap_rdy = (state==IDLE) and is decoded from the registered state.
- IDLE and bus_en&&bus_ap_ndp: on that edge, latch ap_sel, ap_addr, ap_write and ap_wdata (wdata is latched for reads too), move to BUSY and set ap_req=1. Effect: ap_req is high and ap_rdy is low from the cycle after bus_en.
- Posted read: the front end samples rdbuff in the bus_en cycle, so an AP read returns the result of the previous AP read. The new result lands in rdbuff on completion.
- BUSY: ap_req stays high and all ap_* outputs stay stable until a cycle with ap_req&&ap_ack. On that edge, return to IDLE and clear ap_req.
  - On completion without error, a read loads rdbuff <= ap_rdata.
  - On completion with ap_slverr: set sticky_err and leave rdbuff unchanged, for reads and writes alike.
  - A write never modifies rdbuff.
- ap_ack while ap_req=0 is ignored.
- bus_en&&bus_ap_ndp while BUSY is a front-end protocol violation. It is ignored: no latch update, no second request.
- DP accesses (bus_ap_ndp=0) never start a transaction. A DP read of address 3 (RDBUFF) is served from rdbuff with no side effect.
- abort while BUSY: clear ap_req and go to IDLE on that edge. A coincident ap_ack is discarded (no rdbuff update, no sticky set). abort while IDLE has no effect.
- sticky_err: set on a slverr completion and cleared on clr_sticky_err. If both occur on the same edge, set wins. While sticky_err is high, the DP faults AP accesses, so bus_en does not arrive; the block still accepts one if it does.
- Back-to-back: IDLE-to-BUSY is legal on the same edge as BUSY-to-IDLE only via a separate cycle. The earliest next accept is one cycle after completion, when ap_rdy is high.

Test Plan:
- Posted read: preload rdbuff=0, AP read addr 1 with APBANKSEL=2 → ap_req next cycle, ap_addr=6'h09, ap_write=0; ack with ap_rdata=32'hCAFEF00D → rdbuff=CAFEF00D, ap_rdy=1. A second AP read samples CAFEF00D.
- Write: AP write 32'h12345678 addr 0, ack delayed 5 cycles → ap_req high for exactly 6 cycles with stable outputs, ap_rdy low throughout, rdbuff unchanged.
- Slave error: read acked with slverr=1, ap_rdata=32'hFFFFFFFF → sticky_err=1, rdbuff unchanged. clr_sticky_err coincident with a second slverr ack → sticky_err stays 1; a lone clr → 0.
- Abort: abort 2 cycles into BUSY, then ap_ack on the next cycle → ap_req=0, ap_rdy=1 after the abort edge, rdbuff and sticky_err unchanged.
- Protocol violation and DP access: bus_en AP write while BUSY → latched ap_wdata unchanged and single request; DP RDBUFF read → no ap_req.
- Reset mid-transaction: assert rst_n low while BUSY → ap_req drops immediately; all outputs return to reset values.
